// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two valid/ready
// requesters: registered ALU drive, one-cycle result capture, per-requester response.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [3:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_y,
  output logic             r0_zero,
  output logic             r0_err,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [3:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_y,
  output logic             r1_zero,
  output logic             r1_err,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_r;
  logic             gnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] y_r;
  logic             z_r;
  logic             err_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             rsp_hs_s;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8, 4'd10: op_legal = 1'b1;
      default:                       op_legal = 1'b0;
    endcase
  endfunction

  // Grant offered only while idle; last_r=1 means r1 was served last, so r0 wins a tie
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (r0_valid && r1_valid) begin
        grant0_s = last_r;
        grant1_s = !last_r;
      end else begin
        grant0_s = r0_valid;
        grant1_s = r1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Response handshake for the requester currently being served
  always_comb begin
    if (gnt_r) begin
      rsp_hs_s = rsp1_valid_r && r1_rsp_ready;
    end else begin
      rsp_hs_s = rsp0_valid_r && r0_rsp_ready;
    end
  end

  // Sequencer: accept, drive ALU, capture result, hold response until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_r       <= 1'b1;
      gnt_r        <= 1'b0;
      op_r         <= 4'd0;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      y_r          <= {WIDTH{1'b0}};
      z_r          <= 1'b0;
      err_r        <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            gnt_r   <= grant1_s;
            op_r    <= grant1_s ? r1_op : r0_op;
            a_r     <= grant1_s ? r1_a : r0_a;
            b_r     <= grant1_s ? r1_b : r0_b;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          // Illegal codes never sample the ALU, so an undefined result cannot leak out
          if (op_legal(op_r)) begin
            y_r   <= alu_y;
            z_r   <= alu_zero;
            err_r <= 1'b0;
          end else begin
            y_r   <= {WIDTH{1'b0}};
            z_r   <= 1'b0;
            err_r <= 1'b1;
          end
          rsp0_valid_r <= !gnt_r;
          rsp1_valid_r <= gnt_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_hs_s) begin
            last_r       <= gnt_r;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign r0_ready     = grant0_s;
  assign r1_ready     = grant1_s;
  assign alu_ctrl     = op_r;
  assign alu_a1       = a_r;
  assign alu_a2       = b_r;
  assign r0_rsp_valid = rsp0_valid_r;
  assign r1_rsp_valid = rsp1_valid_r;
  assign r0_y         = y_r;
  assign r1_y         = y_r;
  assign r0_zero      = z_r;
  assign r1_zero      = z_r;
  assign r0_err       = err_r;
  assign r1_err       = err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a transaction-level model predicts grants
// and queues expected responses; a separate monitor pops and compares them.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_zero, r0_err;
  logic         r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_zero, r1_err;
  logic [3:0]   r0_op, r1_op, alu_ctrl;
  logic [W-1:0] r0_a, r0_b, r0_y, r1_a, r1_b, r1_y, alu_a1, alu_a2, alu_y;
  logic         alu_zero;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_y(r0_y), .r0_zero(r0_zero), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_y(r1_y), .r1_zero(r1_zero), .r1_err(r1_err),
    .alu_ctrl(alu_ctrl), .alu_a1(alu_a1), .alu_a2(alu_a2),
    .alu_y(alu_y), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Attached ALU; an illegal code yields a junk pattern standing in for an undefined result
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a << b[4:0];
      4'd4:    return a >> b[4:0];
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a - b;
      4'd7:    return a ^ b;
      4'd8:    return ~(a | b);
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign alu_y    = alu_fn(alu_ctrl, alu_a1, alu_a2);
  assign alu_zero = (alu_y == {W{1'b0}});

  typedef struct {
    int           who;
    logic [W-1:0] y;
    logic         z;
    logic         e;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: one operation in flight, response due two samples after accept
  bit m_free = 1'b1;
  int m_last = 1;
  int m_who  = 0;
  int m_due  = 0;
  always @(negedge clk) begin : model
    int           g;
    logic         legal;
    logic [W-1:0] ey;
    exp_t         ex;
    if (reset) begin
      m_free = 1'b1;
      m_last = 1;
    end else if (!m_free) begin
      chk("ready_busy", {r1_ready, r0_ready}, 2'b00);
      if (cyc >= m_due && ((m_who == 1) ? r1_rsp_ready : r0_rsp_ready)) begin
        m_free = 1'b1;
        m_last = m_who;
      end
    end else begin
      g = -1;
      if (r0_valid && r1_valid) g = (m_last == 1) ? 0 : 1;
      else if (r0_valid) g = 0;
      else if (r1_valid) g = 1;
      chk("ready_idle", {r1_ready, r0_ready}, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
      if (g >= 0) begin
        legal  = (g == 0) ? ((r0_op <= 4'd8) || (r0_op == 4'd10))
                          : ((r1_op <= 4'd8) || (r1_op == 4'd10));
        ey     = (g == 0) ? alu_fn(r0_op, r0_a, r0_b) : alu_fn(r1_op, r1_a, r1_b);
        ex.who = g;
        ex.y   = legal ? ey : {W{1'b0}};
        ex.z   = legal && (ey == {W{1'b0}});
        ex.e   = !legal;
        ex.due = cyc + 2;
        q.push_back(ex);
        m_free = 1'b0;
        m_who  = g;
        m_due  = cyc + 2;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a response
  exp_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t dropped;
    if (reset) begin
      q.delete();
      have_cur = 1'b0;
    end else begin
      if (!have_cur && (r0_rsp_valid || r1_rsp_valid)) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b%b expected none (cycle %0d)",
                   r1_rsp_valid, r0_rsp_valid, cyc);
        end else begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          chk("rsp_latency", cyc, cur.due);
        end
      end else if (!have_cur && q.size() > 0 && cyc > q[0].due) begin
        checks++;
        $display("FAIL rsp_timeout: got no response expected one at cycle %0d", q[0].due);
        dropped = q.pop_front();
      end
      if (have_cur) begin
        chk("rsp_valid", {r1_rsp_valid, r0_rsp_valid}, (cur.who == 1) ? 2'b10 : 2'b01);
        chk("rsp_y",    (cur.who == 1) ? r1_y : r0_y, cur.y);
        chk("rsp_zero", (cur.who == 1) ? r1_zero : r0_zero, cur.z);
        chk("rsp_err",  (cur.who == 1) ? r1_err : r0_err, cur.e);
        if ((cur.who == 1) ? r1_rsp_ready : r0_rsp_ready) have_cur = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int who, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit keep, output int acc);
    bit done = 1'b0;
    acc = -1;
    if (who == 1) begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    else          begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if ((who == 1) ? r1_ready : r0_ready) begin done = 1'b1; acc = cyc; end
    end
    step(1);
    if (!keep) begin
      if (who == 1) r1_valid = 1'b0;
      else          r0_valid = 1'b0;
    end
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: got no ready expected accept of r%0d", who);
    end
  endtask

  task automatic expect_rsp(input int who, input logic [W-1:0] y, input logic z,
                            input logic e);
    int n = 0;
    @(negedge clk);
    while (!((who == 1) ? r1_rsp_valid : r0_rsp_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      $display("FAIL dir_rsp_timeout: got no rsp_valid expected one for r%0d", who);
    end else begin
      chk("dir_y",    (who == 1) ? r1_y : r0_y, y);
      chk("dir_zero", (who == 1) ? r1_zero : r0_zero, z);
      chk("dir_err",  (who == 1) ? r1_err : r0_err, e);
      chk("dir_other_valid", (who == 1) ? r0_rsp_valid : r1_rsp_valid, 1'b0);
    end
  endtask

  initial begin
    int c1, c2, dummy;
    reset = 1'b1;
    r0_valid = 1'b0; r0_op = 4'd0; r0_a = '0; r0_b = '0; r0_rsp_ready = 1'b1;
    r1_valid = 1'b0; r1_op = 4'd0; r1_a = '0; r1_b = '0; r1_rsp_ready = 1'b1;
    step(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", alu_ctrl, 4'd0);
    chk("rst_a1", alu_a1, 32'd0);
    chk("rst_a2", alu_a2, 32'd0);
    chk("rst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
    chk("rst_y", r0_y, 32'd0);
    step(1);

    // Single add
    send(0, 4'd2, 32'd5, 32'd7, 1'b0, dummy);
    expect_rsp(0, 32'd12, 1'b0, 1'b0);
    step(3);

    // Tie round-robin on subtract
    r0_op = 4'd6; r0_a = 32'd3; r0_b = 32'd3;
    r1_op = 4'd6; r1_a = 32'd9; r1_b = 32'd4;
    r0_valid = 1'b1; r1_valid = 1'b1;
    step(13);
    r0_valid = 1'b0; r1_valid = 1'b0;
    step(4);

    // Response backpressure with r0 waiting
    r1_rsp_ready = 1'b0;
    send(1, 4'd7, 32'hF0, 32'hFF, 1'b0, dummy);
    r0_valid = 1'b1; r0_op = 4'd1; r0_a = 32'h30; r0_b = 32'h0C;
    expect_rsp(1, 32'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    step(1);
    r1_rsp_ready = 1'b1;
    send(0, 4'd1, 32'h30, 32'h0C, 1'b0, dummy);
    expect_rsp(0, 32'h3C, 1'b0, 1'b0);
    step(3);

    // Illegal op then a legal AND
    send(0, 4'd9, 32'h1234, 32'h5678, 1'b0, dummy);
    expect_rsp(0, 32'd0, 1'b0, 1'b1);
    send(0, 4'd0, 32'hC, 32'hA, 1'b0, dummy);
    expect_rsp(0, 32'd8, 1'b0, 1'b0);
    step(3);

    // Asynchronous reset during EXEC of an r1 op
    send(1, 4'd2, 32'd11, 32'd22, 1'b0, dummy);
    chk("exec_ctrl", alu_ctrl, 4'd2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, 2'b00);
    chk("midrst_ctrl", alu_ctrl, 4'd0);
    chk("midrst_a1", alu_a1, 32'd0);
    chk("midrst_a2", alu_a2, 32'd0);
    @(negedge clk);
    step(1);
    reset = 1'b0;
    r0_valid = 1'b1; r0_op = 4'd2; r0_a = 32'd1; r0_b = 32'd1;
    r1_valid = 1'b1; r1_op = 4'd2; r1_a = 32'd2; r1_b = 32'd2;
    @(negedge clk);
    chk("postrst_ready", {r1_ready, r0_ready}, 2'b01);
    step(1);
    r0_valid = 1'b0; r1_valid = 1'b0;
    step(5);

    // Back-to-back shift then signed compare from r0
    send(0, 4'd3, 32'd1, 32'd4, 1'b1, c1);
    send(0, 4'd5, 32'd2, 32'd3, 1'b0, c2);
    chk("b2b_gap", c2 - c1, 32'd3);
    step(5);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r0_valid     = ($urandom_range(0, 2) != 0);
      r1_valid     = ($urandom_range(0, 2) != 0);
      r0_op        = 4'($urandom_range(0, 15));
      r1_op        = 4'($urandom_range(0, 15));
      r0_a         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      r0_b         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      r1_a         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      r1_b         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    step(10);
    chk("drain", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
